uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped transmit-only UART on the CPU data bus of the f8 test system. Captures byte writes from the CPU write port into a small FIFO and serialises them on `txd` as 8N1 frames. Exposes a status word on the data read path so firmware can poll for space. Also echoes each transmitted byte to the simulation console, so test programs can print without a host-side decoder.

## Interface
Parameters:
- `BASE_ADDR`, 16'hff00: word-aligned base; DATA at +0, STATUS at +2.
- `CLK_DIV`, 16: clock cycles per serial bit, ≥2.
- `FIFO_DEPTH`, 8: entries, power of two, ≥2.
- `SIM_ECHO`, 1: when 1, each byte popped for transmission is printed with `$write("%c")`.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dwrite_addr`  in  16  CPU write address.
- `dwrite_data`  in  16  CPU write data; bits [7:0] are used.
- `dwrite_en`  in  1  write strobe, sampled at `posedge clk`.
- `dread_addr`  in  16  CPU read address.
- `status_sel`  out  1  combinational; 1 when `dread_addr[15:1] == BASE_ADDR[15:1]+1`.
- `status_data`  out  16  combinational status word, valid whenever `status_sel`; 0 otherwise.
- `txd`  out  1  serial line, idle high.
- `tx_idle`  out  1  1 when FIFO empty and FSM in IDLE.

## Operation
- DATA write: `dwrite_en && dwrite_addr[15:1] == BASE_ADDR[15:1]` pushes `dwrite_data[7:0]`.
- If the FIFO is full, the push is dropped and sticky `overflow` is set. Fullness is evaluated before any same-cycle pop, so a write to a full FIFO is dropped even if a pop occurs in that cycle.
- STATUS write (address +2, bit0 = 1): clears `overflow`. Other bits are ignored.
- `status_data` fields:
  - bit0 `full`
  - bit1 `empty`
  - bit2 `busy` (FSM not IDLE)
  - bit3 `overflow`
  - bits[11:8] FIFO count, saturating at 15
  - other bits 0
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. Pop into the shift register in that cycle.
  - START drives 0 for `CLK_DIV` cycles, then → DATA.
  - DATA drives shift[0] for `CLK_DIV` cycles per bit, 8 bits, LSB first, then → STOP.
  - STOP drives 1 for `CLK_DIV` cycles. On the last cycle: if non-empty, pop and go directly to START (back-to-back frames, no extra idle bit); otherwise → IDLE.
- Counters: bit-timer counts `CLK_DIV-1` down to 0; 3-bit bit index. Widths are `$clog2(CLK_DIV)` and `$clog2(FIFO_DEPTH)+1` for the count.
- Reset (async, any state, including mid-frame) sets:
  - `txd`=1, FSM=IDLE
  - FIFO empty, `overflow`=0
  - `tx_idle`=1
  - Status at reset: `empty`=1, all other bits 0.

## Timing
- Push at edge N → count/`empty` updated after N.
- FSM pops at edge N+1 → `txd` falls after N+1.
- One frame occupies exactly 10·`CLK_DIV` cycles. Back-to-back frames have no gap.
- Simultaneous push and pop on a non-full FIFO: both succeed, count unchanged.
- Pointers wrap modulo `FIFO_DEPTH`; count distinguishes full from empty.
- `status_data` and `status_sel` are purely combinational from `dread_addr` and current registers, so they are usable by the single-cycle read mux in the same cycle.

## Structure
- Package `f8_periph_pkg`:
  - `UART_DATA_OFS`=0, `UART_STAT_OFS`=2
  - status bit position constants
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t`
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): push/pop/full/empty/count, async active-low reset. Reusable by a future RX block.
- Top holds the address decode, status mux, FSM, bit timer and shifter.

## Test plan
- Reset then write 8'h55 with `CLK_DIV`=4 → `txd` low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; `tx_idle` returns 1 at cycle 41.
- Write 8'h41, 8'h42 on consecutive cycles → two frames totalling exactly 80 cycles with no gap; console shows "AB".
- With the FSM busy, write 9 bytes into `FIFO_DEPTH`=8 → status reads `full`=1, count=8, `overflow`=1, and the 9th byte is never transmitted. Write 1 to STATUS → `overflow`=0.
- Deassert `reset_n` asynchronously mid-DATA → `txd`=1 and status=16'h0002 immediately without a clock edge. After release, no residual frame is emitted.
- Read `dread_addr`=BASE+2 → `status_sel`=1. Read BASE+4 or BASE+0 → `status_sel`=0, `status_data`=0.
- Write to BASE+4 → no push, count unchanged.

Source files
------------

// File: rtl/f8_periph_pkg.sv
// Shared constants and types for the f8 test-system peripherals.
// Register offsets are byte offsets from a peripheral's word-aligned base.
package f8_periph_pkg;

  localparam logic [15:0] UART_DATA_OFS = 16'd0;
  localparam logic [15:0] UART_STAT_OFS = 16'd2;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  // The status word has a 4-bit count field; deeper FIFOs report 15.
  function automatic logic [3:0] sat_count4(input int unsigned c);
    return (c > 15) ? 4'hf : c[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and occupancy count.
// Pushes to a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 transmit UART: DATA writes feed a FIFO drained by the
// serialiser; STATUS reads expose FIFO/FSM state, STATUS bit0 write clears overflow.
module uart_tx_mmio
  import f8_periph_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hff00,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter bit          SIM_ECHO   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic        dwrite_en,
  input  logic [15:0] dread_addr,
  output logic        status_sel,
  output logic [15:0] status_data,
  output logic        txd,
  output logic        tx_idle
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]   DATA_ADDR  = BASE_ADDR + UART_DATA_OFS;
  localparam logic [15:0]   STAT_ADDR  = BASE_ADDR + UART_STAT_OFS;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLK_DIV - 1);

  uart_tx_state_t r_state, w_state_next;
  logic [TW-1:0]  r_timer, w_timer_next;
  logic [2:0]     r_bit_idx, w_bit_idx_next;
  logic [7:0]     r_shift, w_shift_next;
  logic           r_overflow;
  logic           w_pop;
  logic           w_data_wr;
  logic           w_stat_wr;
  logic           w_full;
  logic           w_empty;
  logic [7:0]     w_rdata;
  logic [CW-1:0]  w_count;
  logic           w_unused;

  assign w_data_wr = dwrite_en && (dwrite_addr[15:1] == DATA_ADDR[15:1]);
  assign w_stat_wr = dwrite_en && (dwrite_addr[15:1] == STAT_ADDR[15:1]);
  assign w_unused  = ^{dwrite_data[15:8], dwrite_addr[0], dread_addr[0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_data_wr),
    .i_pop   (w_pop),
    .i_wdata (dwrite_data[7:0]),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A push and an overflow clear can never coincide: they decode different words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_data_wr && w_full) begin
      r_overflow <= 1'b1;
    end else if (w_stat_wr && dwrite_data[0]) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_rdata;
          w_timer_next = TIMER_LOAD;
          w_state_next = START;
        end
      end
      START: begin
        if (r_timer == '0) begin
          w_timer_next   = TIMER_LOAD;
          w_bit_idx_next = 3'd0;
          w_state_next   = DATA;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      DATA: begin
        if (r_timer == '0) begin
          w_timer_next = TIMER_LOAD;
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP;
          end else begin
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      STOP: begin
        // Chain straight into the next start bit so queued frames have no gap.
        if (r_timer == '0) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_rdata;
            w_timer_next = TIMER_LOAD;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (r_state)
      START:   txd = 1'b0;
      DATA:    txd = r_shift[0];
      default: txd = 1'b1;
    endcase
  end

  assign tx_idle    = w_empty && (r_state == IDLE);
  assign status_sel = (dread_addr[15:1] == STAT_ADDR[15:1]);

  always_comb begin
    status_data = 16'h0000;
    if (status_sel) begin
      status_data[STAT_FULL_BIT]                = w_full;
      status_data[STAT_EMPTY_BIT]               = w_empty;
      status_data[STAT_BUSY_BIT]                = (r_state != IDLE);
      status_data[STAT_OVF_BIT]                 = r_overflow;
      status_data[STAT_CNT_LSB+3:STAT_CNT_LSB]  = sat_count4(32'(w_count));
    end
  end

`ifndef SYNTHESIS
  generate
    if (SIM_ECHO) begin : g_echo
      always_ff @(posedge clk) begin
        if (w_pop) $write("%c", w_rdata);
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: frame timing, back-to-back frames, overflow,
// async reset mid-frame and address decode, with a serial-line receiver model.
module tb_uart_tx_mmio;

  localparam int CLK_DIV = 4;

  logic        clk;
  logic        reset_n;
  logic [15:0] dwrite_addr;
  logic [15:0] dwrite_data;
  logic        dwrite_en;
  logic [15:0] dread_addr;
  logic        status_sel;
  logic [15:0] status_data;
  logic        txd;
  logic        tx_idle;

  int n_cmp;
  int n_bad;

  logic [7:0] rx_q[$];
  logic       rx_reset_seen;
  logic [7:0] rx_byte;
  logic       rx_stop;

  uart_tx_mmio #(
    .BASE_ADDR  (16'hff00),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (8),
    .SIM_ECHO   (1'b0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dwrite_addr (dwrite_addr),
    .dwrite_data (dwrite_data),
    .dwrite_en   (dwrite_en),
    .dread_addr  (dread_addr),
    .status_sel  (status_sel),
    .status_data (status_data),
    .txd         (txd),
    .tx_idle     (tx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Receiver model: samples each bit at its centre on the falling clock edge.
  always @(negedge reset_n) rx_reset_seen = 1'b1;

  initial begin
    rx_reset_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && txd === 1'b0) begin
        rx_reset_seen = 1'b0;
        repeat (CLK_DIV + CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx_byte[i] = txd;
          if (i < 7) repeat (CLK_DIV) @(negedge clk);
        end
        repeat (CLK_DIV) @(negedge clk);
        rx_stop = txd;
        if (!rx_reset_seen && rx_stop === 1'b1) rx_q.push_back(rx_byte);
      end
    end
  end

  function automatic logic exp_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    return 1'b1;
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    $display("write addr=%h data=%h", a, d);
    dwrite_addr = a;
    dwrite_data = d;
    dwrite_en   = 1'b1;
    @(posedge clk); #1;
    dwrite_en   = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", tx_idle); end
    n_cmp++; if (status_sel !== 1'b1) begin n_bad++; $display("FAIL reset_sel: got %b want 1", status_sel); end
    n_cmp++; if (status_data !== 16'h0002) begin n_bad++; $display("FAIL reset_status: got %h want 0002", status_data); end
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (status_data !== 16'h0002) begin n_bad++; $display("FAIL post_reset_status: got %h want 0002", status_data); end
    $display("test_reset done");
  endtask

  task automatic test_frame;
    logic e;
    rx_q.delete();
    bus_write(16'hff00, 16'h0055);
    n_cmp++; if (status_data !== 16'h0100) begin n_bad++; $display("FAIL frame_push_status: got %h want 0100", status_data); end
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL frame_pre_txd: got %b want 1", txd); end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      e = exp_bit(8'h55, k / 4);
      n_cmp++; if (txd !== e) begin n_bad++; $display("FAIL frame_txd[%0d]: got %b want %b", k, txd, e); end
      if (k == 0) begin
        n_cmp++; if (status_data !== 16'h0006) begin n_bad++; $display("FAIL frame_busy_status: got %h want 0006", status_data); end
      end
      if (k == 39) begin
        n_cmp++; if (tx_idle !== 1'b0) begin n_bad++; $display("FAIL frame_idle_c40: got %b want 0", tx_idle); end
      end
    end
    @(posedge clk); #1;
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL frame_idle_c41: got %b want 1", tx_idle); end
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (rx_q.size() !== 1) begin n_bad++; $display("FAIL frame_rx_count: got %0d want 1", rx_q.size()); end
    if (rx_q.size() == 1) begin
      n_cmp++; if (rx_q[0] !== 8'h55) begin n_bad++; $display("FAIL frame_rx_byte: got %h want 55", rx_q[0]); end
    end
    $display("test_frame done");
  endtask

  task automatic test_back_to_back;
    logic e;
    rx_q.delete();
    bus_write(16'hff00, 16'h0041);
    bus_write(16'hff00, 16'h0042);
    n_cmp++; if (status_data !== 16'h0104) begin n_bad++; $display("FAIL b2b_status: got %h want 0104", status_data); end
    for (int k = 0; k < 80; k++) begin
      e = exp_bit((k < 40) ? 8'h41 : 8'h42, (k % 40) / 4);
      n_cmp++; if (txd !== e) begin n_bad++; $display("FAIL b2b_txd[%0d]: got %b want %b", k, txd, e); end
      if (k == 79) begin
        n_cmp++; if (tx_idle !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_c80: got %b want 0", tx_idle); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_c81: got %b want 1", tx_idle); end
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (rx_q.size() !== 2) begin n_bad++; $display("FAIL b2b_rx_count: got %0d want 2", rx_q.size()); end
    if (rx_q.size() == 2) begin
      n_cmp++; if (rx_q[0] !== 8'h41) begin n_bad++; $display("FAIL b2b_rx0: got %h want 41", rx_q[0]); end
      n_cmp++; if (rx_q[1] !== 8'h42) begin n_bad++; $display("FAIL b2b_rx1: got %h want 42", rx_q[1]); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_overflow;
    int cyc;
    rx_q.delete();
    for (int i = 0; i < 10; i++) bus_write(16'hff00, 16'h0030 + 16'(i));
    n_cmp++; if (status_data !== 16'h080d) begin n_bad++; $display("FAIL ovf_status: got %h want 080d", status_data); end
    bus_write(16'hff02, 16'h0001);
    n_cmp++; if (status_data !== 16'h0805) begin n_bad++; $display("FAIL ovf_clear: got %h want 0805", status_data); end
    bus_write(16'hff04, 16'h0099);
    n_cmp++; if (status_data !== 16'h0805) begin n_bad++; $display("FAIL off_map_write: got %h want 0805", status_data); end
    cyc = 0;
    while (tx_idle !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++; if (cyc >= 2000) begin n_bad++; $display("FAIL ovf_drain: got %0d cycles want <2000", cyc); end
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (rx_q.size() !== 9) begin n_bad++; $display("FAIL ovf_rx_count: got %0d want 9", rx_q.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < rx_q.size()) begin
        n_cmp++;
        if (rx_q[i] !== 8'h30 + 8'(i)) begin
          n_bad++; $display("FAIL ovf_rx[%0d]: got %h want %h", i, rx_q[i], 8'h30 + 8'(i));
        end
      end
    end
    n_cmp++; if (status_data !== 16'h0002) begin n_bad++; $display("FAIL ovf_final_status: got %h want 0002", status_data); end
    $display("test_overflow done");
  endtask

  task automatic test_async_reset;
    int lows;
    rx_q.delete();
    bus_write(16'hff00, 16'h00a5);
    bus_write(16'hff00, 16'h005a);
    repeat (10) @(posedge clk); #1;
    n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL arst_pre_txd: got %b want 0", txd); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL arst_txd: got %b want 1", txd); end
    n_cmp++; if (status_data !== 16'h0002) begin n_bad++; $display("FAIL arst_status: got %h want 0002", status_data); end
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL arst_idle: got %b want 1", tx_idle); end
    @(negedge clk);
    reset_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) lows++;
    end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL arst_residual_low: got %0d want 0", lows); end
    n_cmp++; if (rx_q.size() !== 0) begin n_bad++; $display("FAIL arst_rx_count: got %0d want 0", rx_q.size()); end
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL arst_post_idle: got %b want 1", tx_idle); end
    $display("test_async_reset done");
  endtask

  task automatic test_addr_decode;
    dread_addr = 16'hff02; #1;
    n_cmp++; if (status_sel !== 1'b1) begin n_bad++; $display("FAIL dec_sel_ff02: got %b want 1", status_sel); end
    dread_addr = 16'hff03; #1;
    n_cmp++; if (status_sel !== 1'b1) begin n_bad++; $display("FAIL dec_sel_ff03: got %b want 1", status_sel); end
    dread_addr = 16'hff04; #1;
    n_cmp++; if (status_sel !== 1'b0) begin n_bad++; $display("FAIL dec_sel_ff04: got %b want 0", status_sel); end
    n_cmp++; if (status_data !== 16'h0000) begin n_bad++; $display("FAIL dec_data_ff04: got %h want 0000", status_data); end
    dread_addr = 16'hff00; #1;
    n_cmp++; if (status_sel !== 1'b0) begin n_bad++; $display("FAIL dec_sel_ff00: got %b want 0", status_sel); end
    n_cmp++; if (status_data !== 16'h0000) begin n_bad++; $display("FAIL dec_data_ff00: got %h want 0000", status_data); end
    dread_addr = 16'hff02;
    @(posedge clk); #1;
    bus_write(16'hff04, 16'h0077);
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (status_data !== 16'h0002) begin n_bad++; $display("FAIL dec_wr_ff04_status: got %h want 0002", status_data); end
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL dec_wr_ff04_idle: got %b want 1", tx_idle); end
    $display("test_addr_decode done");
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    reset_n     = 1'b0;
    dwrite_addr = 16'h0000;
    dwrite_data = 16'h0000;
    dwrite_en   = 1'b0;
    dread_addr  = 16'hff02;
    test_reset();
    test_frame();
    test_back_to_back();
    test_overflow();
    test_async_reset();
    test_addr_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
